// File: rtl/acc_seq_ctrl_if.sv
// Stream bundle for acc_seq_ctrl: partial-sum input handshake and result output handshake.
// The slave modport is the sequencer's view; master is the upstream/writeback side.
interface acc_seq_ctrl_if #(
    parameter int BIT_WIDTH = 12
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [BIT_WIDTH-1:0] in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic        [BIT_WIDTH-1:0] out_data;
    logic                        out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/acc_seq_ctrl.sv
// Sequencer feeding the bias-reset accumulator from a partial-sum stream and
// capturing its ReLU/saturated result once per output channel.
module acc_seq_ctrl #(
    parameter int BIT_WIDTH  = 12,
    parameter int BIAS_WIDTH = 12,
    parameter int CHN_MAX    = 32,
    parameter int OCH_MAX    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(CHN_MAX+1)-1:0]  cfg_chn,
    input  logic [$clog2(OCH_MAX+1)-1:0]  cfg_och,
    input  logic                          bias_we,
    input  logic [$clog2(OCH_MAX)-1:0]    bias_addr,
    input  logic [BIAS_WIDTH-1:0]         bias_wdata,
    acc_seq_ctrl_if.slave                 stream,
    output logic                          acc_en,
    output logic                          acc_new_bias,
    output logic signed [BIT_WIDTH-1:0]   acc_x,
    output logic signed [BIAS_WIDTH-1:0]  acc_bias,
    input  logic signed [BIT_WIDTH-1:0]   acc_y_relu,
    output logic                          busy,
    output logic                          done
);
    localparam int CW = $clog2(CHN_MAX+1);
    localparam int OW = $clog2(OCH_MAX+1);
    localparam int AW = $clog2(OCH_MAX);

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN1, DRAIN2, OUT} state_t;

    state_t                       state, state_d;
    logic [CW-1:0]                chn_cnt, chn_d, chn_lim, chn_lim_d;
    logic [OW-1:0]                och_cnt, och_d, och_lim, och_lim_d;
    logic                         en_d, nb_d, done_d;
    logic signed [BIT_WIDTH-1:0]  x_d;
    logic signed [BIAS_WIDTH-1:0] bias_d;
    logic                         out_valid_q, ov_d;
    logic [BIT_WIDTH-1:0]         out_data_q, od_d;
    logic                         last_och;
    logic signed [BIAS_WIDTH-1:0] bias_mem [OCH_MAX];

    // Bias memory is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (bias_we)
            bias_mem[bias_addr] <= bias_wdata;
    end

    assign last_och         = (och_cnt == och_lim - OW'(1));
    assign stream.in_ready  = (state == ACCUM);
    assign stream.out_valid = out_valid_q;
    assign stream.out_data  = out_data_q;
    assign stream.out_last  = out_valid_q && last_och;
    assign busy             = (state != IDLE);

    always_comb begin
        state_d   = state;
        chn_d     = chn_cnt;
        och_d     = och_cnt;
        chn_lim_d = chn_lim;
        och_lim_d = och_lim;
        en_d      = 1'b0;
        nb_d      = 1'b0;
        x_d       = acc_x;
        bias_d    = acc_bias;
        ov_d      = out_valid_q;
        od_d      = out_data_q;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    chn_lim_d = (cfg_chn == '0) ? CW'(1) : cfg_chn;
                    och_lim_d = (cfg_och == '0) ? OW'(1) : cfg_och;
                    chn_d     = '0;
                    och_d     = '0;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                if (stream.in_valid) begin
                    en_d   = 1'b1;
                    nb_d   = (chn_cnt == '0);
                    x_d    = stream.in_data;
                    bias_d = bias_mem[och_cnt[AW-1:0]];
                    if (chn_cnt == chn_lim - CW'(1)) begin
                        chn_d   = '0;
                        state_d = DRAIN1;
                    end else begin
                        chn_d = chn_cnt + CW'(1);
                    end
                end
            end
            DRAIN1: state_d = DRAIN2;
            DRAIN2: begin
                od_d    = acc_y_relu;
                ov_d    = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (stream.out_ready) begin
                    ov_d = 1'b0;
                    if (last_och) begin
                        done_d  = 1'b1;
                        och_d   = '0;
                        state_d = IDLE;
                    end else begin
                        och_d   = och_cnt + OW'(1);
                        state_d = ACCUM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            chn_cnt      <= '0;
            och_cnt      <= '0;
            chn_lim      <= CW'(1);
            och_lim      <= OW'(1);
            acc_en       <= 1'b0;
            acc_new_bias <= 1'b0;
            acc_x        <= '0;
            acc_bias     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            done         <= 1'b0;
        end else begin
            state        <= state_d;
            chn_cnt      <= chn_d;
            och_cnt      <= och_d;
            chn_lim      <= chn_lim_d;
            och_lim      <= och_lim_d;
            acc_en       <= en_d;
            acc_new_bias <= nb_d;
            acc_x        <= x_d;
            acc_bias     <= bias_d;
            out_valid_q  <= ov_d;
            out_data_q   <= od_d;
            done         <= done_d;
        end
    end
endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Bench for acc_seq_ctrl: accumulator stub, per-cycle stream/transaction model,
// and directed runs with literal expected results.
module tb_acc_seq_ctrl;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [5:0]        cfg_chn = '0;
    logic [4:0]        cfg_och = '0;
    logic              bias_we = 1'b0;
    logic [3:0]        bias_addr = '0;
    logic [11:0]       bias_wdata = '0;
    logic              acc_en, acc_new_bias, busy, done;
    logic signed [11:0] acc_x, acc_bias, acc_y;
    int                acc_sum = 0;

    int n_tests = 0;
    int n_fail  = 0;

    acc_seq_ctrl_if #(.BIT_WIDTH(12)) bus ();

    acc_seq_ctrl #(
        .BIT_WIDTH(12), .BIAS_WIDTH(12), .CHN_MAX(32), .OCH_MAX(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_chn(cfg_chn), .cfg_och(cfg_och),
        .bias_we(bias_we), .bias_addr(bias_addr), .bias_wdata(bias_wdata),
        .stream(bus), .acc_en(acc_en), .acc_new_bias(acc_new_bias),
        .acc_x(acc_x), .acc_bias(acc_bias), .acc_y_relu(acc_y),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int sat_relu(input int s);
        int r;
        r = s;
        if (r > 2047)  r = 2047;
        if (r < -2048) r = -2048;
        if (r < 0)     r = 0;
        return r;
    endfunction

    // Accumulator stub: registered sum, saturating ReLU view on its output.
    always @(posedge clk)
        if (acc_en)
            acc_sum <= acc_new_bias ? int'(acc_bias) + int'(acc_x) : acc_sum + int'(acc_x);
    assign acc_y = 12'(sat_relu(acc_sum));

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model, sampled on negedge ----------------
    bit run_active = 0, awaiting = 0, pend_en = 0, pend_nb = 0, done_pend = 0;
    int m_chn = 1, m_och = 1, beat_idx = 0, och_idx = 0;
    int grp_sum = 0, grp_bias = 0, exp_val = 0, t_last = 0, cyc = 0;
    int pend_x = 0, pend_bias = 0;
    int bias_model [16];
    int got [$];
    int en_cnt = 0, nb_cnt = 0, done_cnt = 0, ov_cnt = 0;

    always @(negedge clk) begin
        bit was_active, exp_ov, beat;
        was_active = run_active;
        if (rst) begin
            run_active = 0; awaiting = 0; pend_en = 0; done_pend = 0;
            beat_idx = 0; och_idx = 0;
            chk("rst_acc_en", int'(acc_en), 0);
            chk("rst_out_valid", int'(bus.out_valid), 0);
            chk("rst_busy", int'(busy), 0);
        end else begin
            if (acc_en) en_cnt++;
            if (acc_new_bias) nb_cnt++;
            if (done) done_cnt++;
            if (bus.out_valid) ov_cnt++;
            chk("acc_en", int'(acc_en), int'(pend_en));
            if (pend_en) begin
                chk("acc_x", int'(acc_x), pend_x);
                chk("acc_new_bias", int'(acc_new_bias), int'(pend_nb));
                chk("acc_bias", int'(acc_bias), pend_bias);
            end else begin
                chk("acc_new_bias_idle", int'(acc_new_bias), 0);
            end
            chk("in_ready", int'(bus.in_ready), int'(run_active && !awaiting));
            chk("busy", int'(busy), int'(run_active));
            exp_ov = awaiting && (cyc >= t_last + 3);
            chk("out_valid", int'(bus.out_valid), int'(exp_ov));
            if (exp_ov) begin
                chk("out_data", int'(bus.out_data), exp_val);
                chk("out_last", int'(bus.out_last), int'(och_idx == m_och - 1));
            end else begin
                chk("out_last_idle", int'(bus.out_last), 0);
            end
            chk("done", int'(done), int'(done_pend));

            beat = run_active && !awaiting && bus.in_valid;
            pend_en = beat;
            if (beat) begin
                pend_x    = int'(bus.in_data);
                pend_nb   = (beat_idx == 0);
                pend_bias = bias_model[och_idx];
                if (beat_idx == 0) begin
                    grp_bias = pend_bias;
                    grp_sum  = 0;
                end
                grp_sum += pend_x;
                beat_idx++;
                if (beat_idx == m_chn) begin
                    beat_idx = 0;
                    awaiting = 1;
                    t_last   = cyc;
                    exp_val  = sat_relu(grp_bias + grp_sum);
                end
            end
            done_pend = 0;
            if (exp_ov && bus.out_ready) begin
                got.push_back(int'(bus.out_data));
                awaiting = 0;
                if (och_idx == m_och - 1) begin
                    done_pend  = 1;
                    run_active = 0;
                    och_idx    = 0;
                end else begin
                    och_idx++;
                end
            end
            if (start && !was_active) begin
                run_active = 1;
                m_chn = (cfg_chn == 0) ? 1 : int'(cfg_chn);
                m_och = (cfg_och == 0) ? 1 : int'(cfg_och);
                beat_idx = 0; och_idx = 0; awaiting = 0;
            end
        end
        if (bias_we) bias_model[bias_addr] = int'($signed(bias_wdata));
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bias(input int addr, input int val);
        bias_we = 1'b1; bias_addr = 4'(addr); bias_wdata = 12'(val);
        tick();
        bias_we = 1'b0;
    endtask

    task automatic run_start(input int chn, input int och);
        start = 1'b1; cfg_chn = 6'(chn); cfg_och = 5'(och);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int d, input int gap);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 12'(d);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1; break; end
        end
        tick();
        bus.in_valid = 1'b0;
        chk("send_timeout", int'(ok), 1);
        repeat (gap) tick();
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        chk("done_timeout", int'(ok), 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e0, n0, d0, o0;
        bit seen;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        repeat (2) tick();
        chk("reset_out_data", int'(bus.out_data), 0);
        chk("reset_in_ready", int'(bus.in_ready), 0);
        rst = 1'b0;
        tick();

        // Basic group: 100 + 10 + 20 + 30
        set_bias(0, 100);
        e0 = en_cnt; n0 = nb_cnt; d0 = done_cnt;
        run_start(3, 1);
        send(10, 0); send(20, 0); send(30, 0);
        wait_done();
        chk("t1_result", got[$], 160);
        chk("t1_en_pulses", en_cnt - e0, 3);
        chk("t1_nb_pulses", nb_cnt - n0, 1);
        chk("t1_done_pulses", done_cnt - d0, 1);

        // Saturation and ReLU
        set_bias(0, 2000);
        run_start(2, 1);
        send(100, 0); send(100, 0);
        wait_done();
        chk("t2_saturate", got[$], 2047);
        set_bias(0, -50);
        run_start(2, 1);
        send(10, 0); send(10, 0);
        wait_done();
        chk("t3_relu", got[$], 0);

        // Back-pressure for 5 OUT cycles; stray start and in_valid must be ignored
        bus.out_ready = 1'b0;
        set_bias(0, 7);
        run_start(1, 1);
        send(5, 0);
        o0 = ov_cnt;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin seen = 1; break; end
        end
        chk("t4_valid_timeout", int'(seen), 1);
        tick();
        bus.in_valid = 1'b1; bus.in_data = 12'(999);
        start = 1'b1; cfg_chn = 6'(3); cfg_och = 5'(3);
        tick();
        start = 1'b0;
        tick(); tick();
        chk("t4_in_ready_low", int'(bus.in_ready), 0);
        tick();
        bus.out_ready = 1'b1; bus.in_valid = 1'b0;
        wait_done();
        chk("t4_result", got[$], 12);
        chk("t4_valid_cycles", ov_cnt - o0, 6);

        // Two output channels with distinct biases
        set_bias(0, 5);
        set_bias(1, -5);
        run_start(2, 2);
        send(1, 0); send(1, 0); send(1, 0); send(1, 0);
        wait_done();
        chk("t5_first", got[$-1], 7);
        chk("t5_second", got[$], 0);
        chk("t5_busy_low", int'(busy), 0);

        // Sparse input stream
        set_bias(0, 100);
        run_start(3, 1);
        send(10, 2); send(20, 2); send(30, 2);
        wait_done();
        chk("t6_gaps", got[$], 160);

        // Bias rewrite mid-group only affects later beats (which do not reload bias)
        set_bias(0, 100);
        run_start(2, 1);
        send(1, 0);
        set_bias(0, 500);
        send(2, 0);
        wait_done();
        chk("t7_bias_midrun", got[$], 103);

        // Reset mid-run, then a clean run
        set_bias(0, 0);
        run_start(3, 1);
        send(1, 0);
        rst = 1'b1;
        #1;
        chk("t8_rst_acc_en", int'(acc_en), 0);
        chk("t8_rst_busy", int'(busy), 0);
        chk("t8_rst_in_ready", int'(bus.in_ready), 0);
        tick();
        rst = 1'b0;
        tick();
        run_start(3, 1);
        send(1, 0); send(2, 0); send(3, 0);
        wait_done();
        chk("t8_result", got[$], 6);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
